rr_req_gnt_arbiter: RTL and testbench
=====================================

Name: rr_req_gnt_arbiter

Overview:
Round-robin arbiter that shares one req/gnt-style resource (the registered request→grant responder used in our interface/clocking training designs) between N requesters. It sits between the per-requester interfaces and the shared resource.
- At most one requester holds the grant at a time.
- Grant ownership is bounded by a hold timeout.
- Output is one-hot grant plus an encoded owner ID.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant, ≥ 2.
- ID_W, $clog2(N_REQ): width of gnt_id (derived, localparam).
- CNT_W, $clog2(MAX_HOLD+1): width of the hold counter (derived, localparam).

Ports:
- clk, input, 1: single clock, all state updates on posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, N_REQ: per-requester request, level; held high while the resource is wanted.
- gnt, output, N_REQ: one-hot grant, registered.
- gnt_id, output, ID_W: index of current owner; valid only while gnt_vld=1.
- gnt_vld, output, 1: equals |gnt, registered.
- timeout, output, 1: one-cycle pulse on forced revocation.

Behaviour:
- **Reset:** rst_n low asynchronously clears gnt=0, gnt_id=0, gnt_vld=0, timeout=0, hold counter=0, rr pointer=0 and state=IDLE. This holds even mid-grant, with no completion cycle. After release, requester 0 has highest priority.
- **States:** IDLE, GRANT, GAP.
- **IDLE:** at a posedge with req≠0, pick a winner, then go to GRANT.
  - Winner = first set bit scanning from ptr upward, wrapping modulo N_REQ.
  - gnt[winner]=1 and gnt_id=winner after that edge, so latency is 1 cycle from sampled req.
  - ptr ← winner+1, with wrap.
  - If req=0, stay in IDLE.
- **GRANT:** the hold counter increments every cycle in GRANT. It is reset to 1 on entry.
  - Owner req sampled 0: gnt drops after that edge, then go to GAP. No timeout.
  - Owner req still 1 and counter == MAX_HOLD: gnt drops, timeout=1 for exactly one cycle, then go to GAP. This is the forced revoke.
  - Otherwise hold the grant. Requests from non-owners are ignored while in GRANT.
- **GAP:** exactly one cycle with gnt=0, then the same arbitration as IDLE. A pending req goes straight to GRANT; req=0 goes to IDLE.
- **Owner release timing:** release-to-next-grant is 2 edges, i.e. one dead cycle.
- **Re-grant after timeout:** a revoked owner whose req is still high may win again only through normal rotation. The pointer has already passed it, so others win first if they are requesting.
- **Simultaneous release and timeout on the same edge:** treated as a release, so timeout stays 0.
- **Invariants:** gnt is never multi-hot. gnt_vld == |gnt. gnt_id is held at its last value when gnt_vld=0.

Optional Feature:
Macro ARB_BACK2BACK_EN.
- **Defined:**
  - On release or timeout, if another requester (excluding the outgoing owner) has req=1 at that edge, grant it on the same edge with no GAP cycle.
  - gnt moves one-hot to one-hot and gnt_vld stays 1.
  - The timeout pulse is still generated on a forced revoke.
  - If no other requester is pending, behaviour is as without the macro.
- **Undefined:** the GAP cycle is always inserted, as specified above.

Decomposition:
- **Package arb_pkg:**
  - typedef enum logic [1:0] arb_state_t {IDLE, GRANT, GAP}.
  - Default constants for N_REQ and MAX_HOLD.
  - Function next_ptr(idx, n) for wrap-around increment.
- **Sub-module rr_pick:** a combinational rotate-priority picker.
  - Inputs: req, ptr, and an exclude mask.
  - Outputs: winner index and found flag.
  - Parameterised by N_REQ and instantiated once in the arbiter.

Test Plan (N_REQ=4, MAX_HOLD=16):
1. **Reset and idle:** rst_n=0, then release with req=4'b0000 → gnt=0, gnt_vld=0, timeout=0 for 10 cycles.
2. **Single request:** req=4'b0010 sampled at edge k → gnt=4'b0010 and gnt_id=1 after edge k. Drop req at edge k+5 → gnt=0 after k+5.
3. **Rotation:** req=4'b1111 held high, each owner releases after 3 cycles and re-asserts → grant order 0,1,2,3,0, with one GAP cycle between grants.
4. **Timeout:** req=4'b0001 held for 40 cycles → grant lasts exactly 16 cycles, timeout pulses once, GAP, then re-grant to 0 (sole requester).
5. **Timeout with competitor:** req=4'b0011 held → after req[0] is revoked, requester 1 wins next.
6. **Async reset mid-grant:** reset during GRANT (owner 2) → gnt=0 immediately without waiting for clk. After release with req=4'b0101, requester 0 wins. With ARB_BACK2BACK_EN, scenario 3 shows no GAP cycles.

Source files
------------

// File: rtl/rr_req_gnt_arbiter_pkg.sv
// Shared types/constants for the round-robin req/gnt arbiter.
// Optional feature macro: ARB_BACK2BACK_EN (direct owner-to-owner handover).
package arb_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} arb_state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 16;

  function automatic int next_ptr(input int idx, input int n);
     return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_req_gnt_arbiter_if.sv
// Requester-side bundle: level requests in, one-hot grant / owner id / timeout out.
interface rr_req_gnt_arbiter_if
   import arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic             gnt_vld;
   logic             timeout;

   modport master (output req, input gnt, gnt_id, gnt_vld, timeout);
   modport slave  (input req, output gnt, gnt_id, gnt_vld, timeout);

endinterface

// File: rtl/rr_req_gnt_arbiter_pick.sv
// Rotating-priority picker: first requester at or after ptr (wrapping), skipping excluded bits.
module rr_pick #(
   parameter int N_REQ = 4,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   input  logic [N_REQ-1:0] i_excl,
   output logic [ID_W-1:0]  o_win,
   output logic             o_found
);

   int w_j;

   always_comb begin
      o_win   = '0;
      o_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= N_REQ) w_j = w_j - N_REQ;
         if (!o_found && i_req[w_j] && !i_excl[w_j]) begin
            o_found = 1'b1;
            o_win   = ID_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter with hold timeout: IDLE -> GRANT -> GAP -> (GRANT|IDLE).
// With ARB_BACK2BACK_EN a pending non-owner takes over on release/revoke with no GAP cycle.
module rr_req_gnt_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   localparam int ID_W    = $clog2(N_REQ),
   localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   rr_req_gnt_arbiter_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_GRANT = GRANT;
   localparam logic [1:0] ST_GAP   = GAP;

   logic [1:0]       r_state;
   logic [N_REQ-1:0] r_gnt;
   logic [ID_W-1:0]  r_gnt_id;
   logic             r_gnt_vld;
   logic             r_timeout;
   logic [CNT_W-1:0] r_cnt;
   logic [ID_W-1:0]  r_ptr;

   logic             w_in_grant;
   logic             w_owner_req;
   logic             w_release;
   logic             w_revoke;
   logic             w_end;
   logic             w_b2b;
   logic             w_take;
   logic [N_REQ-1:0] w_excl;
   logic [ID_W-1:0]  w_win;
   logic             w_found;

   assign w_in_grant  = (r_state == ST_GRANT);
   assign w_owner_req = |(bus.req & r_gnt);
   assign w_release   = w_in_grant && !w_owner_req;
   // Release wins over revoke on the same edge, so timeout only fires if the owner still wants it.
   assign w_revoke    = w_in_grant && w_owner_req && (r_cnt == CNT_W'(MAX_HOLD));
   assign w_end       = w_release || w_revoke;
   assign w_excl      = w_in_grant ? r_gnt : '0;

`ifdef ARB_BACK2BACK_EN
   assign w_b2b = w_end && w_found;
`else
   assign w_b2b = 1'b0;
`endif

   assign w_take = w_in_grant ? w_b2b : w_found;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .i_excl  (w_excl),
      .o_win   (w_win),
      .o_found (w_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_gnt_vld <= 1'b0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
         r_ptr     <= '0;
      end else begin
         r_timeout <= w_revoke;
         if (w_take) begin
            r_gnt     <= N_REQ'(1) << w_win;
            r_gnt_id  <= w_win;
            r_gnt_vld <= 1'b1;
            r_cnt     <= CNT_W'(1);
            r_ptr     <= ID_W'(next_ptr(int'(w_win), N_REQ));
            r_state   <= ST_GRANT;
         end else if (w_end) begin
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_state   <= ST_GAP;
         end else if (w_in_grant) begin
            r_cnt     <= r_cnt + CNT_W'(1);
         end else begin
            r_state   <= ST_IDLE;
         end
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.gnt_id  = r_gnt_id;
   assign bus.gnt_vld = r_gnt_vld;
   assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed bench for rr_req_gnt_arbiter (N_REQ=4, MAX_HOLD=16); honours ARB_BACK2BACK_EN.
module tb_rr_req_gnt_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rr_req_gnt_arbiter_if #(.N_REQ(4)) bus ();

   rr_req_gnt_arbiter #(.N_REQ(4), .MAX_HOLD(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req = 4'b0000;
      rst_n   = 1'b0;
      #2;
      rst_n   = 1'b1;
   endtask

   task automatic test_reset();
      bus.req = 4'b0000;
      rst_n   = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (bus.gnt !== 4'b0000 || bus.gnt_vld !== 1'b0 || bus.timeout !== 1'b0 || bus.gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: gnt=%b vld=%b to=%b id=%0d want 0000/0/0/0",
                     i, bus.gnt, bus.gnt_vld, bus.timeout, bus.gnt_id);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.req = 4'b0010;
      step();
      checks++;
      if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1 || bus.gnt_vld !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: gnt=%b id=%0d vld=%b want 0010/1/1", bus.gnt, bus.gnt_id, bus.gnt_vld);
      end
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL single_hold edge %0d: gnt=%b want 0010", i, bus.gnt);
         end
      end
      bus.req = 4'b0000;
      step();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.gnt_vld !== 1'b0 || bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL single_release: gnt=%b vld=%b to=%b want 0000/0/0", bus.gnt, bus.gnt_vld, bus.timeout);
      end
      step();
      checks++;
      if (bus.gnt_id !== 2'd1 || bus.gnt_vld !== 1'b0) begin
         errors++;
         $display("FAIL single_id_held: id=%0d vld=%b want 1/0", bus.gnt_id, bus.gnt_vld);
      end
   endtask

   task automatic test_rotation();
      int owner;
      int nxt;
      logic [3:0] exp;
      do_reset();
      bus.req = 4'b1111;
      step();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
         errors++;
         $display("FAIL rot_first: gnt=%b id=%0d want 0001/0", bus.gnt, bus.gnt_id);
      end
      owner = 0;
      for (int r = 0; r < 4; r++) begin
         step();
         step();
         bus.req[owner] = 1'b0;
         step();
         nxt = (owner + 1) % 4;
         exp = 4'b0001 << nxt;
`ifdef ARB_BACK2BACK_EN
         bus.req[owner] = 1'b1;
`else
         checks++;
         if (bus.gnt !== 4'b0000 || bus.gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL rot_gap %0d: gnt=%b vld=%b want 0000/0", r, bus.gnt, bus.gnt_vld);
         end
         bus.req[owner] = 1'b1;
         step();
`endif
         checks++;
         if (bus.gnt !== exp || bus.gnt_id !== 2'(nxt) || bus.gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL rot_next %0d: gnt=%b id=%0d vld=%b want %b/%0d/1", r, bus.gnt, bus.gnt_id, bus.gnt_vld, exp, nxt);
         end
         owner = nxt;
      end
   endtask

   task automatic test_timeout();
      do_reset();
      bus.req = 4'b0001;
      step();
      for (int i = 1; i <= 15; i++) begin
         step();
         checks++;
         if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_hold edge %0d: gnt=%b to=%b want 0001/0", i, bus.gnt, bus.timeout);
         end
      end
      step();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1) begin
         errors++;
         $display("FAIL to_revoke: gnt=%b to=%b want 0000/1", bus.gnt, bus.timeout);
      end
      step();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0 || bus.gnt_id !== 2'd0) begin
         errors++;
         $display("FAIL to_regrant: gnt=%b to=%b id=%0d want 0001/0/0", bus.gnt, bus.timeout, bus.gnt_id);
      end
      bus.req = 4'b0000;
      step();
   endtask

   task automatic test_timeout_competitor();
      do_reset();
      bus.req = 4'b0011;
      step();
      for (int i = 1; i <= 15; i++) begin
         step();
         checks++;
         if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL comp_hold edge %0d: gnt=%b want 0001", i, bus.gnt);
         end
      end
      step();
`ifdef ARB_BACK2BACK_EN
      checks++;
      if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b1 || bus.gnt_vld !== 1'b1) begin
         errors++;
         $display("FAIL comp_b2b: gnt=%b to=%b vld=%b want 0010/1/1", bus.gnt, bus.timeout, bus.gnt_vld);
      end
`else
      checks++;
      if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1) begin
         errors++;
         $display("FAIL comp_revoke: gnt=%b to=%b want 0000/1", bus.gnt, bus.timeout);
      end
      step();
      checks++;
      if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1 || bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL comp_next: gnt=%b id=%0d to=%b want 0010/1/0", bus.gnt, bus.gnt_id, bus.timeout);
      end
`endif
   endtask

   task automatic test_release_at_limit();
      do_reset();
      bus.req = 4'b0001;
      step();
      for (int i = 1; i <= 15; i++) step();
      bus.req = 4'b0000;
      step();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL limit_release: gnt=%b to=%b want 0000/0", bus.gnt, bus.timeout);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.req = 4'b0100;
      step();
      checks++;
      if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
         errors++;
         $display("FAIL ar_grant: gnt=%b id=%0d want 0100/2", bus.gnt, bus.gnt_id);
      end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.gnt !== 4'b0000 || bus.gnt_vld !== 1'b0 || bus.gnt_id !== 2'd0) begin
         errors++;
         $display("FAIL ar_clear: gnt=%b vld=%b id=%0d want 0000/0/0", bus.gnt, bus.gnt_vld, bus.gnt_id);
      end
      bus.req = 4'b0101;
      #1;
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
         errors++;
         $display("FAIL ar_after: gnt=%b id=%0d want 0001/0", bus.gnt, bus.gnt_id);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      bus.req = 4'b0000;
      test_reset();
      test_single();
      test_rotation();
      test_timeout();
      test_timeout_competitor();
      test_release_at_limit();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1);
   end

endmodule
